// File: rtl/ibex_prefetch_buffer_mq.sv
// ibex_prefetch_buffer_mq
//   Instruction prefetcher with up to NUM_REQS outstanding bus requests and a
//   FIFO_DEPTH-word first-word-fall-through output FIFO. Produces word-aligned
//   32-bit fetch words with their address and error flag; compressed
//   realignment is left to the IF stage.
//
// Parameters
//   NUM_REQS   : max granted-but-not-returned bus requests (1..8)
//   FIFO_DEPTH : output FIFO entries in words (NUM_REQS..16)
//
// Optional feature
//   IBEX_PREFETCH_STALL_ON_ERR_EN : once an erroneous word is pushed, stop
//   issuing new requests until the next branch_i.
//
// Ports
//   clk_i, rst_i                    : clock, synchronous active-high reset
//   req_i, branch_i, addr_i         : IF-stage fetch enable / redirect / target
//   ready_i, valid_o, rdata_o,
//   addr_o, err_o                   : output word handshake
//   instr_req_o, instr_gnt_i,
//   instr_addr_o, instr_rdata_i,
//   instr_err_i, instr_pmp_err_i,
//   instr_rvalid_i                  : instruction bus
//   busy_o                          : request active or responses pending
module ibex_prefetch_buffer_mq #(
  parameter int unsigned NUM_REQS   = 2,
  parameter int unsigned FIFO_DEPTH = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] addr_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        err_o,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  input  logic        instr_pmp_err_i,
  input  logic        instr_rvalid_i,
  output logic        busy_o
);

  localparam int unsigned CW = $clog2(NUM_REQS + 1);
  localparam int unsigned FW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned SW = 6;

  // Request tracking
  logic [CW-1:0]       out_cnt_q, out_cnt_d;
  logic [CW-1:0]       disc_cnt_q, disc_cnt_d;
  logic                hold_q;
  logic                hold_disc_q, hold_disc_d;
  logic [31:0]         hold_addr_q;
  logic [31:0]         fetch_addr_q;
  logic [31:0]         push_addr_q;

  // Per-slot PMP error flags, in grant order
  logic [NUM_REQS-1:0] pmp_flag_q;
  logic [PW-1:0]       pmp_wr_q, pmp_rd_q;

  // Output FIFO, entry 0 is the head
  logic [FW-1:0]       fifo_cnt_q;
  logic [31:0]         fifo_rdata_q [FIFO_DEPTH];
  logic [31:0]         fifo_addr_q  [FIFO_DEPTH];
  logic                fifo_err_q   [FIFO_DEPTH];

  logic [31:0]         branch_addr;
  logic [SW-1:0]       occupancy;
  logic                space_ok, cnt_ok, stall_block;
  logic                issue, gnt, rvalid, ret_err, drop, push, pop;
  logic [AW-1:0]       wr_idx;
  logic                unused_addr_lsb;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NUM_REQS - 1)) ? '0 : p + 1'b1;
  endfunction

  assign branch_addr     = {addr_i[31:2], 2'b00};
  assign unused_addr_lsb = ^addr_i[1:0];

  // Words already owed to the FIFO. A branch discards everything in flight
  // and clears the FIFO, so only a still-held request remains counted.
  assign occupancy = branch_i ? SW'(hold_q)
                              : SW'(fifo_cnt_q) + SW'(out_cnt_q) - SW'(disc_cnt_q) + SW'(hold_q);
  assign space_ok  = occupancy < SW'(FIFO_DEPTH);
  assign cnt_ok    = out_cnt_q < CW'(NUM_REQS);

`ifdef IBEX_PREFETCH_STALL_ON_ERR_EN
  logic err_stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_stall_q <= 1'b0;
    end else if (branch_i) begin
      err_stall_q <= 1'b0;
    end else if (push && ret_err) begin
      err_stall_q <= 1'b1;
    end
  end

  assign stall_block = err_stall_q & ~branch_i;
`else
  assign stall_block = 1'b0;
`endif

  assign issue        = req_i & ~hold_q & cnt_ok & space_ok & ~stall_block;
  assign instr_req_o  = hold_q | issue;
  assign instr_addr_o = hold_q ? hold_addr_q : (branch_i ? branch_addr : fetch_addr_q);

  // PMP errors are accepted in the address phase and never see a bus rvalid
  assign gnt     = instr_req_o & (instr_gnt_i | instr_pmp_err_i);
  assign rvalid  = (out_cnt_q != '0) & (instr_rvalid_i | pmp_flag_q[pmp_rd_q]);
  assign ret_err = instr_err_i | pmp_flag_q[pmp_rd_q];
  assign drop    = rvalid & (disc_cnt_q != '0);
  assign push    = rvalid & ~drop & ~branch_i;
  assign pop     = valid_o & ready_i;
  assign wr_idx  = AW'(fifo_cnt_q - FW'(pop));

  assign valid_o = fifo_cnt_q != '0;
  assign rdata_o = fifo_rdata_q[0];
  assign addr_o  = fifo_addr_q[0];
  assign err_o   = fifo_err_q[0];
  assign busy_o  = instr_req_o | (out_cnt_q != '0);

  // On a branch the held request (if granted now) joins the discard set; a
  // newly issued post-branch request can only be granted when nothing is held.
  // A held request that survives the branch is remembered via hold_disc and
  // added to the discard set when its grant finally arrives.
  always_comb begin
    out_cnt_d   = out_cnt_q + CW'(gnt) - CW'(rvalid);
    disc_cnt_d  = disc_cnt_q;
    hold_disc_d = hold_disc_q;
    if (branch_i) begin
      disc_cnt_d  = out_cnt_q - CW'(rvalid) + CW'(gnt & hold_q);
      hold_disc_d = hold_q & ~gnt;
    end else begin
      disc_cnt_d = disc_cnt_q - CW'(drop) + CW'(gnt & hold_q & hold_disc_q);
      if (gnt) begin
        hold_disc_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_cnt_q    <= '0;
      disc_cnt_q   <= '0;
      hold_q       <= 1'b0;
      hold_disc_q  <= 1'b0;
      hold_addr_q  <= '0;
      fetch_addr_q <= '0;
      push_addr_q  <= '0;
      fifo_cnt_q   <= '0;
    end else begin
      out_cnt_q   <= out_cnt_d;
      disc_cnt_q  <= disc_cnt_d;
      hold_disc_q <= hold_disc_d;

      if (instr_req_o && !gnt) begin
        hold_q      <= 1'b1;
        hold_addr_q <= instr_addr_o;
      end else if (gnt) begin
        hold_q <= 1'b0;
      end

      if (branch_i) begin
        fetch_addr_q <= issue ? branch_addr + 32'd4 : branch_addr;
      end else if (issue) begin
        fetch_addr_q <= fetch_addr_q + 32'd4;
      end

      if (branch_i) begin
        push_addr_q <= branch_addr;
        fifo_cnt_q  <= '0;
      end else begin
        if (push) begin
          push_addr_q <= push_addr_q + 32'd4;
        end
        fifo_cnt_q <= fifo_cnt_q + FW'(push) - FW'(pop);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pmp_flag_q <= '0;
      pmp_wr_q   <= '0;
      pmp_rd_q   <= '0;
    end else begin
      if (rvalid) begin
        pmp_flag_q[pmp_rd_q] <= 1'b0;
        pmp_rd_q             <= ptr_inc(pmp_rd_q);
      end
      if (gnt) begin
        pmp_flag_q[pmp_wr_q] <= instr_pmp_err_i;
        pmp_wr_q             <= ptr_inc(pmp_wr_q);
      end
    end
  end

  // Shift-down FIFO storage; the push slot accounts for a same-cycle pop
  always_ff @(posedge clk_i) begin
    if (pop) begin
      for (int unsigned i = 0; i + 1 < FIFO_DEPTH; i++) begin
        fifo_rdata_q[i] <= fifo_rdata_q[i+1];
        fifo_addr_q[i]  <= fifo_addr_q[i+1];
        fifo_err_q[i]   <= fifo_err_q[i+1];
      end
    end
    if (push) begin
      fifo_rdata_q[wr_idx] <= instr_rdata_i;
      fifo_addr_q[wr_idx]  <= push_addr_q;
      fifo_err_q[wr_idx]   <= ret_err;
    end
  end

  push_never_full : assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && (fifo_cnt_q == FW'(FIFO_DEPTH))));

endmodule
